// File: rtl/aud_pkg.sv
// Shared types and defaults for the audio playback scheduler.
package aud_pkg;

  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_COMMIT_SLOT = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    PAUSE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FAST   = 2'd1,
    SLOW   = 2'd2
  } speed_mode_t;

  // Conflicting fast+slow selections fall back to normal speed.
  function automatic speed_mode_t decode_mode(input logic fast, input logic slow);
    if (fast && !slow) return FAST;
    if (slow && !fast) return SLOW;
    return NORMAL;
  endfunction

endpackage

// File: rtl/aud_lrck_tracker.sv
// Follows the DAC LR clock and raises a one-cycle commit strobe once per frame,
// a fixed number of bclk periods into the right half.
module aud_lrck_tracker
  import aud_pkg::*;
#(
  parameter int COMMIT_SLOT = DEF_COMMIT_SLOT
) (
  input  logic bclk,
  input  logic rst_n,
  input  logic daclrck,
  output logic commit
);

  localparam int SW = $clog2(COMMIT_SLOT + 1);

  logic          lrck_q;
  logic [SW-1:0] slot;
  logic          rise;

  assign rise   = !lrck_q && daclrck;
  assign commit = daclrck && (slot == SW'(COMMIT_SLOT - 1));

  // The slot counter saturates so the commit slot cannot recur within one half.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_q <= 1'b1;
      slot   <= '0;
    end else begin
      lrck_q <= daclrck;
      if (rise)
        slot <= '0;
      else if (daclrck && (slot != SW'(COMMIT_SLOT)))
        slot <= slot + 1'b1;
    end
  end

endmodule

// File: rtl/aud_play_sched.sv
// Playback scheduler: fetches samples from memory ahead of each frame and
// hands them to the DAC serializer at the commit point, honouring speed modes.
module aud_play_sched
  import aud_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int COMMIT_SLOT = DEF_COMMIT_SLOT
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic              i_slow,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [15:0]       i_mem_rdata,
  output logic [15:0]       o_dac_data,
  output logic              o_player_en,
  output logic [1:0]        o_state,
  output logic              o_done,
  output logic              o_underrun
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        hold;
  logic [15:0]       sample_buf;
  logic              buf_valid;
  logic              stop_pend;
  logic              commit;
  logic              ack;
  speed_mode_t       mode;
  logic [ADDR_W:0]   next_addr;
  logic [2:0]        next_hold;
  logic              past_end;
  logic              end_hit;

  aud_lrck_tracker #(.COMMIT_SLOT(COMMIT_SLOT)) u_lrck (
    .bclk    (i_bclk),
    .rst_n   (i_rst_n),
    .daclrck (i_daclrck),
    .commit  (commit)
  );

  assign ack     = o_mem_req && i_mem_ack;
  assign mode    = decode_mode(i_fast, i_slow);
  assign o_state = state;

  // The extra address bit lets a step past the last sample be seen without wrapping.
  always_comb begin
    next_addr = {1'b0, addr} + 1'b1;
    next_hold = '0;
    case (mode)
      FAST: next_addr = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, i_speed} + 1'b1;
      SLOW: begin
        if (hold != i_speed) begin
          next_addr = {1'b0, addr};
          next_hold = hold + 1'b1;
        end
      end
      default: ;
    endcase
    past_end = next_addr > {1'b0, i_end_addr};
    end_hit  = commit && (state == READY) && past_end;
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      hold        <= '0;
      sample_buf  <= '0;
      buf_valid   <= 1'b0;
      stop_pend   <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_dac_data  <= '0;
      o_player_en <= 1'b0;
      o_done      <= 1'b0;
      o_underrun  <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_underrun <= 1'b0;

      if (stop_pend && ack) begin
        o_mem_req <= 1'b0;
        stop_pend <= 1'b0;
      end

      case (state)
        IDLE: o_player_en <= 1'b0;
        FETCH: begin
          if (commit)
            o_underrun <= 1'b1;
          if (ack) begin
            sample_buf <= i_mem_rdata;
            buf_valid  <= 1'b1;
            o_mem_req  <= 1'b0;
            state      <= READY;
          end
        end
        READY: begin
          if (commit) begin
            o_dac_data  <= sample_buf;
            o_player_en <= 1'b1;
            buf_valid   <= 1'b0;
            hold        <= next_hold;
            if (past_end) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end else begin
              addr       <= next_addr[ADDR_W-1:0];
              o_mem_addr <= next_addr[ADDR_W-1:0];
              o_mem_req  <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        PAUSE: begin
          if (ack) begin
            sample_buf <= i_mem_rdata;
            buf_valid  <= 1'b1;
            o_mem_req  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Commands come after the commit handling so they override its next state.
      if (i_stop) begin
        state       <= IDLE;
        addr        <= '0;
        hold        <= '0;
        buf_valid   <= 1'b0;
        o_player_en <= 1'b0;
        o_dac_data  <= '0;
        if (o_mem_req && !i_mem_ack)
          stop_pend <= 1'b1;
        else
          o_mem_req <= 1'b0;
      end else if (i_pause && (state == FETCH || state == READY) && !end_hit) begin
        state       <= PAUSE;
        o_player_en <= 1'b0;
      end else if (i_start && state == IDLE && !stop_pend) begin
        addr       <= '0;
        hold       <= '0;
        buf_valid  <= 1'b0;
        o_mem_addr <= '0;
        o_mem_req  <= 1'b1;
        state      <= FETCH;
      end else if (i_start && state == PAUSE) begin
        if (buf_valid || ack) begin
          state <= READY;
        end else begin
          state <= FETCH;
          if (!o_mem_req) begin
            o_mem_req  <= 1'b1;
            o_mem_addr <= addr;
          end
        end
      end
    end
  end

endmodule
